bp_me_mem_arbiter: RTL and testbench



---
 rtl/bp_cce_pkg.sv | 10 +
 rtl/bp_me_mem_arb_rr.sv | 37 +++
 rtl/bp_me_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bp_me_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE-side types for the memory-end blocks.
package bp_cce_pkg;

   typedef enum logic [1:0] {
      e_arb_idle,
      e_arb_issue,
      e_arb_wait
   } bp_me_mem_arb_state_e;

endpackage

// File: rtl/bp_me_mem_arb_rr.sv
// Combinational rotating-priority picker: first requester at or after rr_i, wrapping.
module bp_me_mem_arb_rr
#(
   parameter int unsigned num_req_p     = 2,
   parameter int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
)
(
   input  logic [num_req_p-1:0]     req_i,
   input  logic [lg_num_req_lp-1:0] rr_i,
   output logic [num_req_p-1:0]     grant_o,
   output logic [lg_num_req_lp-1:0] idx_o,
   output logic                     v_o
);

   logic        found;
   int unsigned pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = 0;
      v_o     = |req_i;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         pos = (32'(rr_i) + k) % num_req_p;
         // Inner loop keeps every index constant after unrolling.
         for (int unsigned i = 0; i < num_req_p; i++) begin
            if (!found && (i == pos) && req_i[i]) begin
               found      = 1'b1;
               grant_o[i] = 1'b1;
               idx_o      = lg_num_req_lp'(i);
            end
         end
      end
   end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// Round-robin arbiter sharing one single-transaction memory port between num_cce_p CCEs.
module bp_me_mem_arbiter
   import bp_cce_pkg::*;
#(
   parameter int unsigned num_cce_p         = 2,
   parameter int unsigned cmd_width_p       = 128,
   parameter int unsigned data_cmd_width_p  = 640,
   parameter int unsigned resp_width_p      = 128,
   parameter int unsigned data_resp_width_p = 640,
   parameter int unsigned lg_num_cce_lp     = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
)
(
   input  logic                                  clk_i,
   input  logic                                  reset_i,

   input  logic [num_cce_p*cmd_width_p-1:0]      cce_mem_cmd_i,
   input  logic [num_cce_p-1:0]                  cce_mem_cmd_v_i,
   output logic [num_cce_p-1:0]                  cce_mem_cmd_yumi_o,

   input  logic [num_cce_p*data_cmd_width_p-1:0] cce_mem_data_cmd_i,
   input  logic [num_cce_p-1:0]                  cce_mem_data_cmd_v_i,
   output logic [num_cce_p-1:0]                  cce_mem_data_cmd_yumi_o,

   output logic [resp_width_p-1:0]               cce_mem_resp_o,
   output logic [num_cce_p-1:0]                  cce_mem_resp_v_o,
   input  logic [num_cce_p-1:0]                  cce_mem_resp_ready_i,

   output logic [data_resp_width_p-1:0]          cce_mem_data_resp_o,
   output logic [num_cce_p-1:0]                  cce_mem_data_resp_v_o,
   input  logic [num_cce_p-1:0]                  cce_mem_data_resp_ready_i,

   output logic [cmd_width_p-1:0]                mem_cmd_o,
   output logic                                  mem_cmd_v_o,
   input  logic                                  mem_cmd_yumi_i,

   output logic [data_cmd_width_p-1:0]           mem_data_cmd_o,
   output logic                                  mem_data_cmd_v_o,
   input  logic                                  mem_data_cmd_yumi_i,

   input  logic [resp_width_p-1:0]               mem_resp_i,
   input  logic                                  mem_resp_v_i,
   output logic                                  mem_resp_ready_o,

   input  logic [data_resp_width_p-1:0]          mem_data_resp_i,
   input  logic                                  mem_data_resp_v_i,
   output logic                                  mem_data_resp_ready_o
);

   bp_me_mem_arb_state_e     state_r, state_n;
   logic [lg_num_cce_lp-1:0] owner_r, owner_n;
   logic [lg_num_cce_lp-1:0] rr_r, rr_n;
   logic                     is_write_r, is_write_n;

   logic [num_cce_p-1:0]     arb_grant;
   logic [lg_num_cce_lp-1:0] arb_idx;
   logic                     arb_v;

   logic [num_cce_p-1:0]        owner_oh;
   logic [cmd_width_p-1:0]      owner_cmd;
   logic [data_cmd_width_p-1:0] owner_data_cmd;
   logic owner_cmd_v, owner_data_cmd_v, owner_resp_ready, owner_data_resp_ready;
   logic [lg_num_cce_lp-1:0]    owner_next;

   bp_me_mem_arb_rr #(
      .num_req_p     (num_cce_p),
      .lg_num_req_lp (lg_num_cce_lp)
   ) u_rr (
      .req_i   (cce_mem_cmd_v_i | cce_mem_data_cmd_v_i),
      .rr_i    (rr_r),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .v_o     (arb_v)
   );

   // Owner-slice selection for payloads, valids and readies.
   always_comb begin
      owner_oh              = '0;
      owner_cmd             = '0;
      owner_data_cmd        = '0;
      owner_cmd_v           = 1'b0;
      owner_data_cmd_v      = 1'b0;
      owner_resp_ready      = 1'b0;
      owner_data_resp_ready = 1'b0;
      for (int unsigned i = 0; i < num_cce_p; i++) begin
         if (owner_r == lg_num_cce_lp'(i)) begin
            owner_oh[i]           = 1'b1;
            owner_cmd             = cce_mem_cmd_i[i*cmd_width_p +: cmd_width_p];
            owner_data_cmd        = cce_mem_data_cmd_i[i*data_cmd_width_p +: data_cmd_width_p];
            owner_cmd_v           = cce_mem_cmd_v_i[i];
            owner_data_cmd_v      = cce_mem_data_cmd_v_i[i];
            owner_resp_ready      = cce_mem_resp_ready_i[i];
            owner_data_resp_ready = cce_mem_data_resp_ready_i[i];
         end
      end
   end

   assign owner_next = (owner_r == lg_num_cce_lp'(num_cce_p - 1)) ? '0 : owner_r + 1'b1;

   always_comb begin
      state_n    = state_r;
      owner_n    = owner_r;
      rr_n       = rr_r;
      is_write_n = is_write_r;

      cce_mem_cmd_yumi_o      = '0;
      cce_mem_data_cmd_yumi_o = '0;
      cce_mem_resp_o          = '0;
      cce_mem_resp_v_o        = '0;
      cce_mem_data_resp_o     = '0;
      cce_mem_data_resp_v_o   = '0;
      mem_cmd_o               = '0;
      mem_cmd_v_o             = 1'b0;
      mem_data_cmd_o          = '0;
      mem_data_cmd_v_o        = 1'b0;
      mem_resp_ready_o        = 1'b0;
      mem_data_resp_ready_o   = 1'b0;

      unique case (state_r)
         e_arb_idle: begin
            if (arb_v) begin
               owner_n    = arb_idx;
               is_write_n = |(arb_grant & cce_mem_data_cmd_v_i);
               state_n    = e_arb_issue;
            end
         end

         e_arb_issue: begin
            if (is_write_r) begin
               mem_data_cmd_o          = owner_data_cmd;
               mem_data_cmd_v_o        = owner_data_cmd_v;
               cce_mem_data_cmd_yumi_o = owner_oh & {num_cce_p{mem_data_cmd_yumi_i & owner_data_cmd_v}};
               // Memory latches response readiness when it accepts the write.
               mem_resp_ready_o        = owner_resp_ready;
               if (mem_data_cmd_yumi_i && owner_data_cmd_v) state_n = e_arb_wait;
            end else begin
               mem_cmd_o          = owner_cmd;
               mem_cmd_v_o        = owner_cmd_v;
               cce_mem_cmd_yumi_o = owner_oh & {num_cce_p{mem_cmd_yumi_i & owner_cmd_v}};
               if (mem_cmd_yumi_i && owner_cmd_v) state_n = e_arb_wait;
            end
         end

         e_arb_wait: begin
            if (is_write_r) begin
               cce_mem_resp_o   = mem_resp_i;
               cce_mem_resp_v_o = owner_oh & {num_cce_p{mem_resp_v_i}};
               mem_resp_ready_o = owner_resp_ready;
               if (mem_resp_v_i && owner_resp_ready) begin
                  rr_n    = owner_next;
                  state_n = e_arb_idle;
               end
            end else begin
               cce_mem_data_resp_o   = mem_data_resp_i;
               cce_mem_data_resp_v_o = owner_oh & {num_cce_p{mem_data_resp_v_i}};
               mem_data_resp_ready_o = owner_data_resp_ready;
               if (mem_data_resp_v_i && owner_data_resp_ready) begin
                  rr_n    = owner_next;
                  state_n = e_arb_idle;
               end
            end
         end

         default: state_n = e_arb_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= e_arb_idle;
         owner_r    <= '0;
         rr_r       <= '0;
         is_write_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         owner_r    <= owner_n;
         rr_r       <= rr_n;
         is_write_r <= is_write_n;
      end
   end

   // An owned request must stay valid until the memory takes it.
   logic owner_v, owner_yumi;
   assign owner_v    = is_write_r ? owner_data_cmd_v : owner_cmd_v;
   assign owner_yumi = is_write_r ? mem_data_cmd_yumi_i : mem_cmd_yumi_i;

   assert property (@(posedge clk_i) disable iff (reset_i)
      (state_r == e_arb_issue && owner_v && !owner_yumi) |=> owner_v);

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Randomized bench for bp_me_mem_arbiter against a transaction-level round-robin model.
module tb_bp_me_mem_arbiter;

   localparam int N   = 3;
   localparam int CW  = 16;
   localparam int DCW = 24;
   localparam int RW  = 12;
   localparam int DRW = 20;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   logic [N*CW-1:0]  cce_mem_cmd;
   logic [N-1:0]     cmd_v, cmd_yumi;
   logic [N*DCW-1:0] cce_mem_data_cmd;
   logic [N-1:0]     dcmd_v, dcmd_yumi;
   logic [RW-1:0]    cce_resp;
   logic [N-1:0]     resp_v, resp_ready;
   logic [DRW-1:0]   cce_dresp;
   logic [N-1:0]     dresp_v, dresp_ready;
   logic [CW-1:0]    mem_cmd;
   logic             mem_cmd_v, mem_cmd_yumi;
   logic [DCW-1:0]   mem_dcmd;
   logic             mem_dcmd_v, mem_dcmd_yumi;
   logic [RW-1:0]    mem_resp;
   logic             mem_resp_v, mem_resp_ready;
   logic [DRW-1:0]   mem_dresp;
   logic             mem_dresp_v, mem_dresp_ready;

   bp_me_mem_arbiter #(
      .num_cce_p         (N),
      .cmd_width_p       (CW),
      .data_cmd_width_p  (DCW),
      .resp_width_p      (RW),
      .data_resp_width_p (DRW)
   ) dut (
      .clk_i                     (clk),
      .reset_i                   (reset_i),
      .cce_mem_cmd_i             (cce_mem_cmd),
      .cce_mem_cmd_v_i           (cmd_v),
      .cce_mem_cmd_yumi_o        (cmd_yumi),
      .cce_mem_data_cmd_i        (cce_mem_data_cmd),
      .cce_mem_data_cmd_v_i      (dcmd_v),
      .cce_mem_data_cmd_yumi_o   (dcmd_yumi),
      .cce_mem_resp_o            (cce_resp),
      .cce_mem_resp_v_o          (resp_v),
      .cce_mem_resp_ready_i      (resp_ready),
      .cce_mem_data_resp_o       (cce_dresp),
      .cce_mem_data_resp_v_o     (dresp_v),
      .cce_mem_data_resp_ready_i (dresp_ready),
      .mem_cmd_o                 (mem_cmd),
      .mem_cmd_v_o               (mem_cmd_v),
      .mem_cmd_yumi_i            (mem_cmd_yumi),
      .mem_data_cmd_o            (mem_dcmd),
      .mem_data_cmd_v_o          (mem_dcmd_v),
      .mem_data_cmd_yumi_i       (mem_dcmd_yumi),
      .mem_resp_i                (mem_resp),
      .mem_resp_v_i              (mem_resp_v),
      .mem_resp_ready_o          (mem_resp_ready),
      .mem_data_resp_i           (mem_dresp),
      .mem_data_resp_v_i         (mem_dresp_v),
      .mem_data_resp_ready_o     (mem_dresp_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding requests per CCE and the fair-turn pointer.
   bit             rd_pend[N];
   bit             wr_pend[N];
   logic [CW-1:0]  rd_pl[N];
   logic [DCW-1:0] wr_pl[N];
   int             ref_rr     = 0;
   int             refill_pct = 40;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         cmd_v[i]                      = rd_pend[i];
         dcmd_v[i]                     = wr_pend[i];
         cce_mem_cmd[i*CW +: CW]       = rd_pl[i];
         cce_mem_data_cmd[i*DCW +: DCW] = wr_pl[i];
      end
   endtask

   task automatic refill(input int pct);
      for (int i = 0; i < N; i++) begin
         if (!rd_pend[i] && $urandom_range(99) < pct) begin
            rd_pend[i] = 1'b1;
            rd_pl[i]   = CW'($urandom);
         end
         if (!wr_pend[i] && $urandom_range(99) < pct) begin
            wr_pend[i] = 1'b1;
            wr_pl[i]   = DCW'($urandom);
         end
      end
   endtask

   function automatic bit any_pend();
      bit a = 1'b0;
      for (int i = 0; i < N; i++) a |= rd_pend[i] | wr_pend[i];
      return a;
   endfunction

   task automatic chk_quiet(input string tag);
      chk(tag, {cmd_yumi, dcmd_yumi, resp_v, dresp_v, mem_cmd_v, mem_dcmd_v,
                mem_resp_ready, mem_dresp_ready}, '0);
   endtask

   // Runs one transaction whose requests were driven at the previous negedge (DUT idle).
   task automatic do_txn(input bit abort_in_wait);
      int             owner = -1;
      bit             is_w;
      logic [N-1:0]   oh;
      logic [RW-1:0]  rpl;
      logic [DRW-1:0] dpl;
      int             bp;
      for (int k = 0; k < N; k++) begin
         int j = (ref_rr + k) % N;
         if (owner < 0 && (rd_pend[j] || wr_pend[j])) owner = j;
      end
      if (owner < 0) begin
         chk("txn_no_owner", 64'd1, 64'd0);
         return;
      end
      is_w = wr_pend[owner];
      oh   = '0;
      oh[owner] = 1'b1;

      @(negedge clk);
      resp_ready  = N'($urandom);
      dresp_ready = N'($urandom);
      #1;
      chk("issue_wr_v", 64'(mem_dcmd_v), 64'(is_w));
      chk("issue_rd_v", 64'(mem_cmd_v), 64'(!is_w));
      if (is_w) chk("issue_wr_payload", 64'(mem_dcmd), 64'(wr_pl[owner]));
      else      chk("issue_rd_payload", 64'(mem_cmd), 64'(rd_pl[owner]));
      chk("issue_resp_ready", 64'(mem_resp_ready), is_w ? 64'(resp_ready[owner]) : 64'd0);
      chk("issue_dresp_ready", 64'(mem_dresp_ready), 64'd0);

      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         #1;
         chk("issue_hold_v", 64'(is_w ? mem_dcmd_v : mem_cmd_v), 64'd1);
         chk("issue_no_yumi", 64'({cmd_yumi, dcmd_yumi}), 64'd0);
      end

      @(negedge clk);
      if (is_w) mem_dcmd_yumi = 1'b1;
      else      mem_cmd_yumi  = 1'b1;
      #1;
      chk("yumi_wr", 64'(dcmd_yumi), is_w ? 64'(oh) : 64'd0);
      chk("yumi_rd", 64'(cmd_yumi), is_w ? 64'd0 : 64'(oh));

      @(negedge clk);
      mem_dcmd_yumi = 1'b0;
      mem_cmd_yumi  = 1'b0;
      if (is_w) wr_pend[owner] = 1'b0;
      else      rd_pend[owner] = 1'b0;
      refill(refill_pct);
      drive_reqs();
      #1;
      chk("wait_no_cmd_v", 64'({mem_cmd_v, mem_dcmd_v}), 64'd0);
      chk("wait_no_yumi", 64'({cmd_yumi, dcmd_yumi}), 64'd0);
      if (abort_in_wait) return;

      // Latency cycles, sometimes with a response on the wrong channel.
      repeat ($urandom_range(0, 3)) begin
         @(negedge clk);
         resp_ready  = N'($urandom);
         dresp_ready = N'($urandom);
         if (is_w) begin
            mem_dresp_v = 1'($urandom_range(1));
            mem_dresp   = DRW'($urandom);
         end else begin
            mem_resp_v = 1'($urandom_range(1));
            mem_resp   = RW'($urandom);
         end
         #1;
         chk("early_resp_v", 64'(resp_v), 64'd0);
         chk("early_dresp_v", 64'(dresp_v), 64'd0);
         if (is_w) begin
            chk("stray_dresp_ready", 64'(mem_dresp_ready), 64'd0);
            chk("wait_resp_ready", 64'(mem_resp_ready), 64'(resp_ready[owner]));
         end else begin
            chk("stray_resp_ready", 64'(mem_resp_ready), 64'd0);
            chk("wait_dresp_ready", 64'(mem_dresp_ready), 64'(dresp_ready[owner]));
         end
      end

      // Response with owner backpressure for bp cycles.
      bp  = $urandom_range(0, 3);
      rpl = RW'($urandom);
      dpl = DRW'($urandom);
      for (int c = 0; c <= bp; c++) begin
         @(negedge clk);
         resp_ready  = N'($urandom);
         dresp_ready = N'($urandom);
         if (is_w) begin
            mem_dresp_v = 1'b0;
            mem_resp_v  = 1'b1;
            mem_resp    = rpl;
            resp_ready[owner] = (c == bp);
         end else begin
            mem_resp_v  = 1'b0;
            mem_dresp_v = 1'b1;
            mem_dresp   = dpl;
            dresp_ready[owner] = (c == bp);
         end
         #1;
         if (is_w) begin
            chk("resp_v", 64'(resp_v), 64'(oh));
            chk("resp_payload", 64'(cce_resp), 64'(rpl));
            chk("resp_ready", 64'(mem_resp_ready), 64'(c == bp));
            chk("resp_no_dresp_v", 64'(dresp_v), 64'd0);
         end else begin
            chk("dresp_v", 64'(dresp_v), 64'(oh));
            chk("dresp_payload", 64'(cce_dresp), 64'(dpl));
            chk("dresp_ready", 64'(mem_dresp_ready), 64'(c == bp));
            chk("dresp_no_resp_v", 64'(resp_v), 64'd0);
         end
      end

      @(negedge clk);
      mem_resp_v  = 1'b0;
      mem_dresp_v = 1'b0;
      ref_rr      = (owner + 1) % N;
      refill(refill_pct);
      drive_reqs();
      #1;
      chk_quiet("back_to_idle");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b1;
      cce_mem_cmd = '0; cce_mem_data_cmd = '0; cmd_v = '0; dcmd_v = '0;
      resp_ready = '0; dresp_ready = '0;
      mem_cmd_yumi = 1'b0; mem_dcmd_yumi = 1'b0;
      mem_resp = '0; mem_resp_v = 1'b0; mem_dresp = '0; mem_dresp_v = 1'b0;
      for (int i = 0; i < N; i++) begin
         rd_pend[i] = 1'b0; wr_pend[i] = 1'b0; rd_pl[i] = '0; wr_pl[i] = '0;
      end
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      resp_ready  = '1;
      dresp_ready = '1;
      #1;
      chk_quiet("reset_state");

      // Idle with no requests stays idle.
      @(negedge clk);
      #1;
      chk_quiet("idle_no_req");

      // Randomized contention.
      for (int t = 0; t < 60; t++) begin
         if (!any_pend()) begin
            @(negedge clk);
            #1;
            chk_quiet("idle_hold");
            refill(100);
            drive_reqs();
         end
         do_txn(1'b0);
      end

      // Drain outstanding work.
      refill_pct = 0;
      for (int t = 0; t < 4 * N && any_pend(); t++) do_txn(1'b0);
      chk("drained", 64'(any_pend()), 64'd0);

      // Same-CCE read+write: write goes first, then the read.
      rd_pend[1] = 1'b1; rd_pl[1] = 16'h1111;
      wr_pend[1] = 1'b1; wr_pl[1] = 24'h222222;
      drive_reqs();
      do_txn(1'b0);
      do_txn(1'b0);

      // Move pointer away from 0, then reset mid-wait.
      rd_pend[0] = 1'b1; rd_pl[0] = 16'h0a0a;
      drive_reqs();
      do_txn(1'b0);
      rd_pend[1] = 1'b1; rd_pl[1] = 16'h0b0b;
      drive_reqs();
      do_txn(1'b1);
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk_quiet("reset_in_wait");
      ref_rr = 0;

      // Pointer must restart at 0: CCE0 wins over CCE2.
      rd_pend[0] = 1'b1; rd_pl[0] = 16'hc0c0;
      wr_pend[2] = 1'b1; wr_pl[2] = 24'hc2c2c2;
      drive_reqs();
      do_txn(1'b0);
      do_txn(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
